// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: multiplexed 7-segment display controller with a small
// register file for digit data, per-digit enable, per-digit blink and control.
//
// Ports:
//   clk_i    - single clock, rising edge
//   rst_ni   - synchronous active-low reset
//   req_i    - bus access strobe (one access per cycle)
//   we_i     - 1 = write, 0 = read
//   addr_i   - byte address, only [3:2] decoded
//               0x0 DATA (nibble k = digit k), 0x4 EN, 0x8 BLINK,
//               0xC CTRL (bit0 blink_on, bit1 blank_all)
//   be_i     - write byte enables
//   wdata_i  - write data
//   rdata_o  - registered read data, held until the next read
//   an_o     - active-low digit anodes
//   seg_o    - active-low cathodes, bit0 = a ... bit6 = g
module seg_disp_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int DATA_W  = 4 * DIGITS;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [DATA_W-1:0]  data_q;
  logic [DIGITS-1:0]  en_q;
  logic [DIGITS-1:0]  blink_q;
  logic [1:0]         ctrl_q;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [IDX_W-1:0]   idx;
  logic               phase;

  logic [31:0]        rd_val;
  logic [3:0]         nib;
  logic               en_k;
  logic               blink_k;
  logic [DIGITS-1:0]  onehot;
  logic               blank;

  // Active-low hex decode, bit order g..a.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Register file: bits above each register's width are simply dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      en_q    <= '0;
      blink_q <= '0;
      ctrl_q  <= '0;
    end else if (req_i && we_i) begin
      case (addr_i[3:2])
        2'd0: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (be_i[i/8]) data_q[i] <= wdata_i[i];
          end
        end
        2'd1: if (be_i[0]) en_q <= wdata_i[DIGITS-1:0];
        2'd2: if (be_i[0]) blink_q <= wdata_i[DIGITS-1:0];
        default: if (be_i[0]) ctrl_q <= wdata_i[1:0];
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i[3:2])
      2'd0:    rd_val = 32'(data_q);
      2'd1:    rd_val = 32'(en_q);
      2'd2:    rd_val = 32'(blink_q);
      default: rd_val = 32'(ctrl_q);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (req_i && !we_i) begin
      rdata_o <= rd_val;
    end
  end

  // Scan and blink timebases run freely; bus traffic never touches them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      phase     <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Select the current digit by compare rather than variable indexing so that
  // non-power-of-two DIGITS never reaches past the register widths.
  always_comb begin
    nib     = '0;
    en_k    = 1'b0;
    blink_k = 1'b0;
    onehot  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = data_q[4*k +: 4];
        en_k      = en_q[k];
        blink_k   = blink_q[k];
        onehot[k] = 1'b1;
      end
    end
    blank = !en_k || ctrl_q[1] || (ctrl_q[0] && blink_k && !phase);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      an_o  <= '1;
      seg_o <= 7'h7F;
    end else begin
      an_o  <= blank ? '1 : ~onehot;
      seg_o <= blank ? 7'h7F : hex_seg(nib);
    end
  end

endmodule
